// File: rtl/load_store_unit.sv
// load_store_unit
// Data-memory access stage: formats byte/halfword/word stores and loads,
// checks alignment, and runs a req/ack handshake to a variable-latency
// memory while stalling the core until the access completes.
//
// Ports
//   clock, clear        core clock, async active-low reset
//   memRead, memWrite   load / store request from the control unit
//   funct3, addr        access width/signedness and byte address
//   storeData           rs2 value for stores
//   loadData            extended load result (held until next load)
//   stall               freeze PC and register-file write
//   done                one-cycle completion pulse
//   accessFault         misaligned/illegal access (combinational)
//   memReq/memWe/memAddr/memWdata/memBe   registered memory request
//   memAck, memRdata    memory acceptance / read data
module load_store_unit #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           storeData,
  output logic [31:0]           loadData,
  output logic                  stall,
  output logic                  done,
  output logic                  accessFault,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [31:0]           memWdata,
  output logic [3:0]            memBe,
  input  logic                  memAck,
  input  logic [31:0]           memRdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;

  logic [2:0]  f3_q;    // width/sign of the access in flight
  logic [1:0]  off_q;   // byte offset of the access in flight
  logic        access, illegal, misal, start;
  logic [3:0]  be;
  logic [31:0] wdata, rshift, ldfmt;

  always_comb begin
    access  = memRead | memWrite;
    illegal = 1'b0;
    if (memRead && memWrite) illegal = 1'b1;
    else if (memRead)        illegal = (funct3 == 3'd3) || (funct3[2:1] == 2'b11);
    else                     illegal = funct3[2] || (funct3[1:0] == 2'b11);
    misal = ((funct3[1:0] == 2'd2) && (addr[1:0] != 2'b00)) ||
            ((funct3[1:0] == 2'd1) && addr[0]);
    accessFault = access & (illegal | misal);
    start = (state == IDLE) & access & ~accessFault;
    stall = start | (state == BUSY);
  end

  // Lane mask and replicated write data; loads reuse the same mask.
  always_comb begin
    case (funct3[1:0])
      2'd0: begin be = 4'b0001 << addr[1:0]; wdata = {4{storeData[7:0]}};  end
      2'd1: begin be = 4'b0011 << addr[1:0]; wdata = {2{storeData[15:0]}}; end
      default: begin be = 4'b1111;           wdata = storeData;            end
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend.
  always_comb begin
    rshift = memRdata >> {off_q, 3'b000};
    case (f3_q)
      3'd0:    ldfmt = {{24{rshift[7]}},  rshift[7:0]};
      3'd1:    ldfmt = {{16{rshift[15]}}, rshift[15:0]};
      3'd4:    ldfmt = {24'd0, rshift[7:0]};
      3'd5:    ldfmt = {16'd0, rshift[15:0]};
      default: ldfmt = rshift;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state    <= IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      done     <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      memBe    <= '0;
      loadData <= '0;
      f3_q     <= '0;
      off_q    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state    <= BUSY;
          memReq   <= 1'b1;
          memWe    <= memWrite;
          memAddr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
          memBe    <= be;
          memWdata <= wdata;
          f3_q     <= funct3;
          off_q    <= addr[1:0];
        end
        BUSY: if (memAck) begin
          state  <= DONE;
          done   <= 1'b1;
          memReq <= 1'b0;
          memWe  <= 1'b0;
          if (!memWe) loadData <= ldfmt;
        end
        // Same instruction is still presented here; ignore it.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        clear;
  logic        memRead, memWrite, memAck;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData, memRdata;
  logic [31:0] loadData, memAddr, memWdata;
  logic        stall, done, accessFault, memReq, memWe;
  logic [3:0]  memBe;
  int total = 0, bad = 0;
  logic [31:0] ld_model = 32'd0;

  always #5 clock = ~clock;

  load_store_unit #(.ADDR_WIDTH(32)) dut (
    .clock(clock), .clear(clear), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .addr(addr), .storeData(storeData), .loadData(loadData),
    .stall(stall), .done(done), .accessFault(accessFault), .memReq(memReq),
    .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata), .memBe(memBe),
    .memAck(memAck), .memRdata(memRdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---- reference model: arithmetic on access size and byte offset ----
  function automatic int nbytes(input logic [2:0] f3);
    return 1 << (int'(f3) % 4);
  endfunction

  function automatic logic exp_fault(input logic rd, input logic wr,
                                     input logic [2:0] f3, input logic [31:0] a);
    int f = int'(f3);
    if (!(rd || wr)) return 1'b0;
    if (rd && wr) return 1'b1;
    if (rd && !(f == 0 || f == 1 || f == 2 || f == 4 || f == 5)) return 1'b1;
    if (wr && f > 2) return 1'b1;
    return (int'(a % 32'd4) % nbytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int m = ((1 << nbytes(f3)) - 1) << int'(a % 32'd4);
    return 32'(m & 15);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] sd);
    case (nbytes(f3))
      1:       return (sd & 32'hFF) * 32'h0101_0101;
      2:       return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rdata);
    logic [63:0] v;
    int nb = nbytes(f3);
    v = 64'(rdata) >> (8 * int'(a % 32'd4));
    if (nb == 4) return v[31:0];
    v = v & ((64'd1 << (8 * nb)) - 1);
    if (int'(f3) < 4 && v >= (64'd1 << (8 * nb - 1))) v = v - (64'd1 << (8 * nb));
    return v[31:0];
  endfunction

  // Full access: request cycle, waits+1 BUSY cycles, DONE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input int waits);
    logic [31:0] eld;
    eld = wr ? ld_model : exp_load(f3, a, rdata);
    @(negedge clock);
    memRead = rd; memWrite = wr; funct3 = f3; addr = a; storeData = sd; memAck = 1'b0;
    #1;
    chk("req_stall", 32'(stall), 32'd1);
    chk("req_fault", 32'(accessFault), 32'd0);
    chk("req_done", 32'(done), 32'd0);
    chk("req_memreq", 32'(memReq), 32'd0);
    for (int i = 0; i <= waits; i++) begin
      @(negedge clock);
      memAck   = (i == waits);
      memRdata = (i == waits) ? rdata : $urandom;
      #1;
      chk("busy_memreq", 32'(memReq), 32'd1);
      chk("busy_stall", 32'(stall), 32'd1);
      chk("busy_done", 32'(done), 32'd0);
      chk("busy_memaddr", memAddr, a & 32'hFFFF_FFFC);
      chk("busy_memwe", 32'(memWe), 32'(wr));
      chk("busy_membe", 32'(memBe), exp_be(f3, a));
      if (wr) chk("busy_memwdata", memWdata, exp_wdata(f3, sd));
    end
    @(negedge clock);
    memAck = 1'b0;
    #1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_memreq", 32'(memReq), 32'd0);
    chk("done_memwe", 32'(memWe), 32'd0);
    chk("done_loaddata", loadData, eld);
    ld_model = eld;
  endtask

  task automatic do_fault(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a);
    @(negedge clock);
    memRead = rd; memWrite = wr; funct3 = f3; addr = a; memAck = 1'b0;
    #1;
    chk("flt_fault", 32'(accessFault), 32'd1);
    chk("flt_stall", 32'(stall), 32'd0);
    chk("flt_memreq", 32'(memReq), 32'd0);
    @(negedge clock);
    #1;
    chk("flt_memreq2", 32'(memReq), 32'd0);
    chk("flt_done", 32'(done), 32'd0);
    chk("flt_loaddata", loadData, ld_model);
    memRead = 1'b0; memWrite = 1'b0;
  endtask

  initial begin
    logic rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    int kind;
    clear = 1'b0; memRead = 1'b0; memWrite = 1'b0; funct3 = 3'd0;
    addr = 32'd0; storeData = 32'd0; memAck = 1'b0; memRdata = 32'd0;

    // reset state
    @(negedge clock); #1;
    chk("rst_memreq", 32'(memReq), 32'd0);
    chk("rst_memwe", 32'(memWe), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_fault", 32'(accessFault), 32'd0);
    chk("rst_memaddr", memAddr, 32'd0);
    chk("rst_memwdata", memWdata, 32'd0);
    chk("rst_membe", 32'(memBe), 32'd0);
    chk("rst_loaddata", loadData, 32'd0);
    clear = 1'b1;

    // clear in second BUSY cycle abandons the access
    @(negedge clock);
    memRead = 1'b1; funct3 = 3'd2; addr = 32'h40;
    @(negedge clock); memAck = 1'b0;
    @(negedge clock); #1;
    chk("clr_busy2_memreq", 32'(memReq), 32'd1);
    clear = 1'b0; memRead = 1'b0;
    #1;
    chk("clr_memreq_async", 32'(memReq), 32'd0);
    chk("clr_stall", 32'(stall), 32'd0);
    @(negedge clock);
    clear = 1'b1; memAck = 1'b1; memRdata = 32'hDEAD_BEEF;
    #1;
    chk("clr_late_ack_done", 32'(done), 32'd0);
    @(negedge clock);
    memAck = 1'b0;
    #1;
    chk("clr_no_done", 32'(done), 32'd0);
    chk("clr_loaddata", loadData, 32'd0);
    chk("clr_memreq_idle", 32'(memReq), 32'd0);

    // directed cases
    do_access(1'b1, 1'b0, 3'd0, 32'h1003, 32'd0, 32'h80FF_1234, 0);
    chk("lb_value", loadData, 32'hFFFF_FF80);
    do_access(1'b1, 1'b0, 3'd5, 32'h2002, 32'd0, 32'hBEEF_0000, 0);
    chk("lhu_value", loadData, 32'h0000_BEEF);
    do_access(1'b0, 1'b1, 3'd0, 32'h0101, 32'h1234_56AB, 32'd0, 0);
    chk("sb_loaddata_kept", loadData, 32'h0000_BEEF);
    do_access(1'b0, 1'b1, 3'd2, 32'h0200, 32'hCAFE_F00D, 32'd0, 4);
    do_access(1'b1, 1'b0, 3'd1, 32'h0302, 32'd0, 32'h8001_7FFF, 1);
    chk("lh_value", loadData, 32'hFFFF_8001);
    @(negedge clock);
    #1;
    chk("after_done_idle", 32'(done), 32'd0);
    memRead = 1'b0; memWrite = 1'b0;
    do_fault(1'b1, 1'b0, 3'd2, 32'h0006);
    do_fault(1'b0, 1'b1, 3'd1, 32'h0003);
    do_fault(1'b1, 1'b1, 3'd2, 32'h0000);
    do_fault(1'b1, 1'b0, 3'd3, 32'h0000);
    do_fault(1'b0, 1'b1, 3'd4, 32'h0000);

    // randomized accesses against the model
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      rd = $urandom_range(0, 1);
      wr = ~rd;
      if (kind == 0) begin rd = 1'b1; wr = 1'b1; end
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      if (kind < 7) a = a & ~32'(nbytes(f3) - 1);
      if (exp_fault(rd, wr, f3, a))
        do_fault(rd, wr, f3, a);
      else
        do_access(rd, wr, f3, a, $urandom, $urandom, $urandom_range(0, 3));
    end

    @(negedge clock);
    memRead = 1'b0; memWrite = 1'b0;
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
